// File: rtl/inject_packetizer_pkg.sv
// Shared NoC parameters: flit geometry, flit type codes, torus size and header field positions.
package inject_packetizer_pkg;
    localparam int FLIT_SIZE  = 32;
    localparam int TYPE_W     = 2;
    localparam int HEADER_LEN = TYPE_W;
    localparam int VC_W       = 1;
    localparam int XW         = 2;
    localparam int YW         = 2;
    localparam int ZW         = 2;
    localparam int DST_W      = XW + YW + ZW;
    localparam int XSIZE      = 4;
    localparam int YSIZE      = 4;
    localparam int ZSIZE      = 4;
    localparam int CMP_LEN    = 4;

    // Head flit layout, MSB first: type | vc | dst{z,y,x} | cmp | payload
    localparam int TYPE_LSB   = FLIT_SIZE - TYPE_W;
    localparam int VC_LSB     = TYPE_LSB - VC_W;
    localparam int DST_LSB    = VC_LSB - DST_W;
    localparam int CMP_LSB    = DST_LSB - CMP_LEN;
    localparam int HEAD_PLD_W = CMP_LSB;

    localparam logic [TYPE_W-1:0] HEAD_FLIT   = 2'b00;
    localparam logic [TYPE_W-1:0] BODY_FLIT   = 2'b01;
    localparam logic [TYPE_W-1:0] TAIL_FLIT   = 2'b10;
    localparam logic [TYPE_W-1:0] SINGLE_FLIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2
    } pkt_state_t;
endpackage

// File: rtl/inject_packetizer_torus_dist.sv
// Torus hop distance from this node to dst, summed over x/y/z and saturated to the cmp width.
module torus_dist
    import inject_packetizer_pkg::*;
#(
    parameter int cur_x = 0,
    parameter int cur_y = 0,
    parameter int cur_z = 0
) (
    input  logic [DST_W-1:0]   dst,
    output logic [CMP_LEN-1:0] cmp
);
    localparam int CMP_MAX = (1 << CMP_LEN) - 1;

    function automatic int hop(input int cur, input int tgt, input int size);
        int d;
        d = (cur > tgt) ? cur - tgt : tgt - cur;
        return (d > size / 2) ? size - d : d;
    endfunction

    int sum;

    always_comb begin
        sum = hop(cur_x, int'(dst[XW-1:0]), XSIZE)
            + hop(cur_y, int'(dst[XW+YW-1:XW]), YSIZE)
            + hop(cur_z, int'(dst[DST_W-1:XW+YW]), ZSIZE);
        cmp = (sum > CMP_MAX) ? CMP_LEN'(CMP_MAX) : CMP_LEN'(sum);
    end
endmodule

// File: rtl/inject_packetizer.sv
// Packet injector: turns a request plus payload words into head/body/tail flits,
// discarding packets addressed to this node.
module inject_packetizer
    import inject_packetizer_pkg::*;
#(
    parameter int cur_x = 0,
    parameter int cur_y = 0,
    parameter int cur_z = 0,
    parameter int LENW  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [XW+YW+ZW-1:0]            req_dst,
    input  logic [LENW-1:0]                req_len,
    output logic                           req_ready,
    input  logic                           pld_valid,
    input  logic [FLIT_SIZE-HEADER_LEN-1:0] pld_data,
    output logic                           pld_ready,
    input  logic                           stall,
    output logic [FLIT_SIZE-1:0]           flit_out,
    output logic                           flit_valid_out,
    output logic [15:0]                    pkt_sent_cnt,
    output logic [15:0]                    pkt_drop_cnt
);
    localparam logic [DST_W-1:0] SELF_DST = {ZW'(cur_z), YW'(cur_y), XW'(cur_x)};

    pkt_state_t         state;
    logic [LENW-1:0]    idx;
    logic [LENW-1:0]    len_q;
    logic [DST_W-1:0]   dst_q;
    logic [CMP_LEN-1:0] cmp_q;
    logic [CMP_LEN-1:0] cmp_nxt;
    logic [LENW-1:0]    len_eff;
    logic               load_en;
    logic               send_hs;
    logic               last;
    logic [TYPE_W-1:0]  ftype;
    logic [FLIT_SIZE-1:0] flit_nxt;

    torus_dist #(.cur_x(cur_x), .cur_y(cur_y), .cur_z(cur_z)) u_dist (
        .dst (req_dst),
        .cmp (cmp_nxt)
    );

    assign load_en   = ~stall | ~flit_valid_out;
    assign req_ready = (state == ST_IDLE);
    assign pld_ready = (state == ST_SEND) ? load_en : (state == ST_DROP);
    assign send_hs   = (state == ST_SEND) && pld_valid && load_en;
    assign last      = (idx == len_q - LENW'(1));
    assign len_eff   = (req_len == '0) ? LENW'(1) : req_len;

    always_comb begin
        ftype = BODY_FLIT;
        if (idx == '0)
            ftype = (len_q == LENW'(1)) ? SINGLE_FLIT : HEAD_FLIT;
        else if (last)
            ftype = TAIL_FLIT;

        flit_nxt = '0;
        flit_nxt[FLIT_SIZE-1:TYPE_LSB] = ftype;
        if (idx == '0) begin
            flit_nxt[VC_LSB-1:DST_LSB]  = dst_q;
            flit_nxt[DST_LSB-1:CMP_LSB] = cmp_q;
            flit_nxt[HEAD_PLD_W-1:0]    = pld_data[HEAD_PLD_W-1:0];
        end else begin
            flit_nxt[TYPE_LSB-1:0] = pld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            len_q          <= '0;
            dst_q          <= '0;
            cmp_q          <= '0;
            flit_out       <= '0;
            flit_valid_out <= 1'b0;
            pkt_sent_cnt   <= '0;
            pkt_drop_cnt   <= '0;
        end else begin
            // Output register only moves when the router can take it.
            if (load_en) begin
                if (send_hs) begin
                    flit_out       <= flit_nxt;
                    flit_valid_out <= 1'b1;
                end else begin
                    flit_valid_out <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        dst_q <= req_dst;
                        len_q <= len_eff;
                        cmp_q <= cmp_nxt;
                        idx   <= '0;
                        state <= (req_dst == SELF_DST) ? ST_DROP : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (send_hs) begin
                        if (last) begin
                            idx          <= '0;
                            state        <= ST_IDLE;
                            pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
                        end else begin
                            idx <= idx + LENW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (pld_valid) begin
                        if (last) begin
                            idx          <= '0;
                            state        <= ST_IDLE;
                            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                        end else begin
                            idx <= idx + LENW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inject_packetizer.sv
// Bench for inject_packetizer: directed packet scenarios followed by random traffic, all scored by a packet-level model.
module tb_inject_packetizer;
    import inject_packetizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [5:0]  req_dst;
    logic [3:0]  req_len;
    logic        req_ready;
    logic        pld_valid;
    logic [29:0] pld_data;
    logic        pld_ready;
    logic        stall;
    logic [31:0] flit_out;
    logic        flit_valid_out;
    logic [15:0] pkt_sent_cnt;
    logic [15:0] pkt_drop_cnt;

    inject_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_dst        (req_dst),
        .req_len        (req_len),
        .req_ready      (req_ready),
        .pld_valid      (pld_valid),
        .pld_data       (pld_data),
        .pld_ready      (pld_ready),
        .stall          (stall),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .pkt_sent_cnt   (pkt_sent_cnt),
        .pkt_drop_cnt   (pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_IDLE = 0, M_SEND = 1, M_DROP = 2;
    int          m_mode;
    int          m_len;
    int          m_pos;
    logic [5:0]  m_dst;
    logic [3:0]  m_cmp;
    logic        m_valid;
    logic [31:0] m_flit;
    logic [15:0] m_sent;
    logic [15:0] m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Minimal torus distance from node (0,0,0) on a 4x4x4 torus.
    function automatic logic [3:0] ref_cmp(input logic [5:0] dst);
        int s = 0;
        for (int k = 0; k < 3; k++) begin
            int t;
            t = int'((dst >> (2 * k)) & 6'd3);
            s += (t < 4 - t) ? t : 4 - t;
        end
        return (s > 15) ? 4'd15 : 4'(s);
    endfunction

    function automatic logic [31:0] ref_flit(input int pos, input int len, input logic [5:0] dst,
                                             input logic [3:0] cmp, input logic [29:0] d);
        logic [1:0] t;
        if (pos == 0)            t = (len == 1) ? SINGLE_FLIT : HEAD_FLIT;
        else if (pos == len - 1) t = TAIL_FLIT;
        else                     t = BODY_FLIT;
        if (pos == 0) return {t, 1'b0, dst, cmp, d[18:0]};
        return {t, d};
    endfunction

    // One clock: apply inputs, check outputs at negedge, advance the model, return just after posedge.
    task automatic cycle(input logic r, input logic rv, input logic [5:0] dst, input logic [3:0] len,
                         input logic pv, input logic [29:0] d, input logic st);
        logic load;
        rst = r; req_valid = rv; req_dst = dst; req_len = len;
        pld_valid = pv; pld_data = d; stall = st;
        @(negedge clk);
        load = !st || !m_valid;
        chk("req_ready", req_ready, m_mode == M_IDLE);
        chk("pld_ready", pld_ready, (m_mode == M_SEND) ? load : (m_mode == M_DROP));
        chk("flit_valid", flit_valid_out, m_valid);
        chk("flit_out", flit_out, m_flit);
        chk("sent_cnt", pkt_sent_cnt, m_sent);
        chk("drop_cnt", pkt_drop_cnt, m_drop);
        if (!r) begin
            m_mode = M_IDLE; m_pos = 0; m_valid = 1'b0; m_flit = '0; m_sent = '0; m_drop = '0;
        end else begin
            if (load) begin
                if (m_mode == M_SEND && pv) begin
                    m_flit  = ref_flit(m_pos, m_len, m_dst, m_cmp, d);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            case (m_mode)
                M_IDLE: if (rv) begin
                    m_len  = (len == 0) ? 1 : int'(len);
                    m_pos  = 0;
                    m_dst  = dst;
                    m_cmp  = ref_cmp(dst);
                    m_mode = (dst == 6'd0) ? M_DROP : M_SEND;
                end
                M_SEND: if (pv && load) begin
                    m_pos++;
                    if (m_pos == m_len) begin m_mode = M_IDLE; m_sent++; end
                end
                M_DROP: if (pv) begin
                    m_pos++;
                    if (m_pos == m_len) begin m_mode = M_IDLE; m_drop++; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 6'd0, 4'd0, 0, 30'd0, 0);
    endtask

    task automatic word(input logic st);
        logic [29:0] d;
        d = 30'($urandom);
        cycle(1, 0, 6'd0, 4'd0, 1, d, st);
    endtask

    initial begin
        m_mode = M_IDLE; m_len = 1; m_pos = 0; m_dst = '0; m_cmp = '0;
        m_valid = 1'b0; m_flit = '0; m_sent = '0; m_drop = '0;
        rst = 0; req_valid = 0; req_dst = '0; req_len = '0; pld_valid = 0; pld_data = '0; stall = 0;
        #1;
        @(posedge clk); #1;
        cycle(0, 0, 6'd0, 4'd0, 0, 30'd0, 0);
        cycle(0, 0, 6'd0, 4'd0, 0, 30'd0, 0);
        chk("rst_valid", flit_valid_out, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_sent", pkt_sent_cnt, 16'd0);

        // dst (3,0,0), len 1: one wraparound hop
        cycle(1, 1, {2'd0, 2'd0, 2'd3}, 4'd1, 0, 30'd0, 0);
        word(0);
        chk("single_type", flit_out[31:30], SINGLE_FLIT);
        chk("single_cmp", flit_out[22:19], 4'd1);
        chk("single_vc", flit_out[29], 1'b0);
        idle(1);
        chk("single_sent", pkt_sent_cnt, 16'd1);

        // dst (2,2,2), len 3, no stall
        cycle(1, 1, {2'd2, 2'd2, 2'd2}, 4'd3, 0, 30'd0, 0);
        word(0);
        chk("p3_head", flit_out[31:30], HEAD_FLIT);
        chk("p3_cmp", flit_out[22:19], 4'd6);
        word(0);
        chk("p3_body", flit_out[31:30], BODY_FLIT);
        word(0);
        chk("p3_tail", flit_out[31:30], TAIL_FLIT);
        idle(1);

        // same packet, HEAD held by 4 stall cycles
        cycle(1, 1, {2'd2, 2'd2, 2'd2}, 4'd3, 0, 30'd0, 0);
        word(0);
        for (int i = 0; i < 4; i++) begin
            word(1);
            chk("hold_valid", flit_valid_out, 1'b1);
            chk("hold_head", flit_out[31:30], HEAD_FLIT);
        end
        word(0);
        chk("st_body", flit_out[31:30], BODY_FLIT);
        word(0);
        chk("st_tail", flit_out[31:30], TAIL_FLIT);
        idle(1);
        chk("st_sent", pkt_sent_cnt, 16'd3);

        // self-addressed packet is swallowed
        cycle(1, 1, 6'd0, 4'd2, 0, 30'd0, 0);
        word(0);
        chk("drop_v0", flit_valid_out, 1'b0);
        word(0);
        chk("drop_v1", flit_valid_out, 1'b0);
        idle(1);
        chk("drop_cnt1", pkt_drop_cnt, 16'd1);

        // reset after BODY of a 4-flit packet
        cycle(1, 1, 6'd1, 4'd4, 0, 30'd0, 0);
        word(0);
        word(0);
        chk("mid_body", flit_out[31:30], BODY_FLIT);
        cycle(0, 0, 6'd0, 4'd0, 1, 30'h15, 0);
        chk("mid_rst_valid", flit_valid_out, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b1);
        idle(1);
        chk("mid_rel_ready", req_ready, 1'b1);
        idle(2);

        // zero length behaves as one
        cycle(1, 1, 6'd1, 4'd0, 0, 30'd0, 0);
        word(0);
        chk("len0_type", flit_out[31:30], SINGLE_FLIT);
        idle(1);
        chk("len0_sent", pkt_sent_cnt, 16'd1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic        r, rv, pv, st;
            logic [5:0]  dst;
            logic [3:0]  len;
            logic [29:0] d;
            r   = ($urandom_range(0, 599) != 0);
            rv  = ($urandom_range(0, 1) == 1);
            dst = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            pv  = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 9) < 3);
            d   = 30'($urandom);
            cycle(r, rv, dst, len, pv, d, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
